// File: rtl/seq_detect_pkg.sv
// Shared types and helpers for the seq_detect_ctrl pattern-detection controller.
package seq_detect_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READY = 2'b01,
    RUN   = 2'b10,
    DONE  = 2'b11
  } state_e;

  // Lengths of 0 or beyond the register width fall back to the full width.
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
    if (len == 0 || len > max_len) return max_len;
    return len;
  endfunction

endpackage

// File: rtl/seq_shift_match.sv
// History shift register, saturating fill counter and length-masked comparator.
module seq_shift_match #(
  parameter  int PAT_W = 8,
  localparam int LEN_W = $clog2(PAT_W) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             shift_i,
  input  logic             bit_i,
  input  logic             clr_fill_i,
  input  logic [PAT_W-1:0] pattern_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             hit_o
);

  logic [PAT_W-1:0] hist_q;
  logic [PAT_W-1:0] hist_nx;
  logic [PAT_W-1:0] mask;
  logic [LEN_W-1:0] fill_q;
  logic [LEN_W-1:0] fill_nx;

  // hit_o looks at the history as it will be once the incoming bit is shifted in.
  always_comb begin
    hist_nx = {hist_q[PAT_W-2:0], bit_i};
    fill_nx = (fill_q == LEN_W'(PAT_W)) ? fill_q : fill_q + LEN_W'(1);
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (i < int'(len_i));
    end
    hit_o = shift_i && (fill_nx >= len_i) && ((hist_nx & mask) == (pattern_i & mask));
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr_i) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (shift_i) begin
      hist_q <= hist_nx;
      fill_q <= clr_fill_i ? '0 : fill_nx;
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Configurable serial pattern-detection controller: config handshake, start/abort, match counting.
// Optional valid-bit timeout between matches is built when SEQ_DETECT_CTRL_TIMEOUT_EN is defined.
module seq_detect_ctrl
  import seq_detect_pkg::*;
#(
  parameter  int PAT_W        = 8,
  parameter  int CNT_W        = 8,
  parameter  int TIMEOUT_BITS = 255,
  localparam int LEN_W        = $clog2(PAT_W) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic [CNT_W-1:0] cfg_target,
  input  logic             start,
  input  logic             abort,
  input  logic             din_valid,
  input  logic             din,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output state_e           dbg_state
);

  // Config handshake: a transfer happens on a rising edge where cfg_valid && cfg_ready.
  state_e           state_q, state_d;
  logic [PAT_W-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  logic             ovl_q;
  logic [CNT_W-1:0] tgt_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             match_q;
  logic             cfg_hs;
  logic             fin_pend;
  logic             shift;
  logic             clr;
  logic             hit;
  logic             to_hit;

  assign cfg_ready = (state_q == IDLE) || (state_q == READY);
  assign cfg_hs    = cfg_valid && cfg_ready;
  // The final match is pulsing: hold the stream so the count cannot pass the target.
  assign fin_pend  = match_q && (cnt_q == tgt_q);
  assign shift     = (state_q == RUN) && din_valid && !fin_pend;
  assign clr       = (state_q == READY) && start;

  seq_shift_match #(.PAT_W(PAT_W)) u_match (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (clr),
    .shift_i    (shift),
    .bit_i      (din),
    .clr_fill_i (hit && !ovl_q),
    .pattern_i  (pat_q),
    .len_i      (len_q),
    .hit_o      (hit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pat_q <= '0;
      len_q <= LEN_W'(PAT_W);
      ovl_q <= 1'b0;
      tgt_q <= CNT_W'(1);
    end else if (cfg_hs) begin
      pat_q <= cfg_pattern;
      len_q <= LEN_W'(clamp_len(32'(cfg_len), PAT_W));
      ovl_q <= cfg_overlap;
      tgt_q <= (cfg_target == '0) ? CNT_W'(1) : cfg_target;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:  if (cfg_hs) state_d = READY;
      READY: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (hit) cnt_d = cnt_q + CNT_W'(1);
        if (abort)         state_d = READY;
        else if (fin_pend) state_d = DONE;
        else if (to_hit)   state_d = DONE;
      end
      DONE:    state_d = READY;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      match_q <= hit;
    end
  end

`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_BITS + 1);
  logic [TO_W-1:0] to_cnt_q;
  logic            timeout_q;

  // A match on the threshold bit resets the budget instead of timing out.
  assign to_hit = shift && !hit && (to_cnt_q == TO_W'(TIMEOUT_BITS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n || clr || hit) begin
      to_cnt_q <= '0;
    end else if (shift) begin
      to_cnt_q <= to_cnt_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) timeout_q <= 1'b0;
    else        timeout_q <= (state_q == RUN) && !abort && !fin_pend && to_hit;
  end

  assign timeout = timeout_q;
`else
  logic unused_to;
  assign unused_to = ^TIMEOUT_BITS;
  assign to_hit    = 1'b0;
  assign timeout   = 1'b0;
`endif

  assign match     = match_q;
  assign match_cnt = cnt_q;
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl with an expected-event queue checked by a monitor.
module tb_seq_detect_ctrl;
  import seq_detect_pkg::*;

  localparam int W = 27;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic [7:0] cfg_target;
  logic       start;
  logic       abort;
  logic       din_valid;
  logic       din;
  logic       match;
  logic [7:0] match_cnt;
  logic       busy;
  logic       done;
  logic       timeout;
  state_e     dbg_state;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  logic [W-1:0] exp_q[$];

  seq_detect_ctrl #(.PAT_W(8), .CNT_W(8), .TIMEOUT_BITS(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cfg_target  (cfg_target),
    .start       (start),
    .abort       (abort),
    .din_valid   (din_valid),
    .din         (din),
    .match       (match),
    .match_cnt   (match_cnt),
    .busy        (busy),
    .done        (done),
    .timeout     (timeout),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  // Event word: {cycle, match, done, timeout, match_cnt}
  always @(negedge clk) begin
    logic [W-1:0] word;
    logic [W-1:0] e;
    if (match || done || timeout) begin
      word = {16'(cyc), match, done, timeout, match_cnt};
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_event: got %0h required none", word);
      end else begin
        e = exp_q.pop_front();
        chk("event", 32'(word), 32'(e));
      end
    end
  end

  // driver tasks
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      din_valid = 1'b0;
      din       = 1'b0;
      start     = 1'b0;
      abort     = 1'b0;
      cfg_valid = 1'b0;
    end
  endtask

  task automatic configure(input logic [7:0] pat, input logic [3:0] len,
                           input logic ovl, input logic [7:0] tgt);
    @(negedge clk);
    cfg_valid   = 1'b1;
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ovl;
    cfg_target  = tgt;
    @(negedge clk);
    cfg_valid   = 1'b0;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic do_abort(input logic [7:0] cnt);
    @(negedge clk);
    din_valid = 1'b0;
    abort     = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("busy_after_abort", 32'(busy), 32'd0);
    chk("cnt_after_abort", 32'(match_cnt), 32'(cnt));
  endtask

  // m: match expected next cycle; d: done two cycles later; t: done+timeout next cycle
  task automatic drive_bit(input logic b, input logic m, input logic d,
                           input logic t, input logic [7:0] cnt);
    @(negedge clk);
    din_valid = 1'b1;
    din       = b;
    if (m) exp_q.push_back({16'(cyc + 1), 1'b1, 1'b0, 1'b0, cnt});
    if (d) exp_q.push_back({16'(cyc + 2), 1'b0, 1'b1, 1'b0, cnt});
    if (t) exp_q.push_back({16'(cyc + 1), 1'b0, 1'b1, 1'b1, cnt});
  endtask

  logic [6:0] stream7;
  logic [7:0] a5;

  initial begin
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_pattern = '0; cfg_len = '0;
    cfg_overlap = 1'b0; cfg_target = '0; start = 1'b0; abort = 1'b0;
    din_valid = 1'b0; din = 1'b0;
    stream7 = 7'b1011011;
    a5      = 8'hA5;

    // 1: reset state, start ignored in IDLE
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_match", 32'(match), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_cnt", 32'(match_cnt), 32'd0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("idle_start_busy", 32'(busy), 32'd0);
    chk("idle_start_state", 32'(dbg_state), 32'(IDLE));

    // 2: non-overlapping, single match after bit 4
    configure(8'h0B, 4'd4, 1'b0, 8'd2);
    chk("ready_state", 32'(dbg_state), 32'(READY));
    do_start();
    for (int i = 6; i >= 0; i--) drive_bit(stream7[i], (i == 3), 1'b0, 1'b0, 8'd1);
    idle(3);
    chk("nonovl_cnt", 32'(match_cnt), 32'd1);
    chk("nonovl_busy", 32'(busy), 32'd1);
    do_abort(8'd1);

    // 3: overlapping, matches after bits 4 and 7, then done
    configure(8'h0B, 4'd4, 1'b1, 8'd2);
    do_start();
    for (int i = 6; i >= 0; i--)
      drive_bit(stream7[i], (i == 3) || (i == 0), (i == 0), 1'b0, (i == 0) ? 8'd2 : 8'd1);
    idle(4);
    chk("ovl_cnt", 32'(match_cnt), 32'd2);
    chk("ovl_busy", 32'(busy), 32'd0);
    chk("ovl_state", 32'(dbg_state), 32'(READY));

    // 4: valid gaps then abort
    configure(8'h0B, 4'd4, 1'b0, 8'd2);
    do_start();
    for (int i = 6; i >= 3; i--) begin
      drive_bit(stream7[i], (i == 3), 1'b0, 1'b0, 8'd1);
      idle(3);
    end
    idle(2);
    do_abort(8'd1);
    idle(3);
    chk("abort_no_done_state", 32'(dbg_state), 32'(READY));

    // 5: timeout after 8 non-matching bits
    configure(8'h0B, 4'd4, 1'b0, 8'd1);
    do_start();
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
    for (int i = 0; i < 8; i++) drive_bit(1'b0, 1'b0, 1'b0, (i == 7), 8'd0);
    idle(3);
    chk("to_busy", 32'(busy), 32'd0);
    chk("to_cnt", 32'(match_cnt), 32'd0);
`else
    for (int i = 0; i < 8; i++) drive_bit(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    idle(3);
    chk("noto_busy", 32'(busy), 32'd1);
    do_abort(8'd0);
`endif

    // 6: reset mid-run, then full-width length via cfg_len=0
    do_start();
    drive_bit(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    drive_bit(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    @(negedge clk);
    din_valid = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_state", 32'(dbg_state), 32'(IDLE));
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_cnt", 32'(match_cnt), 32'd0);
    configure(8'hA5, 4'd0, 1'b0, 8'd1);
    do_start();
    for (int i = 7; i >= 0; i--) drive_bit(a5[i], (i == 0), (i == 0), 1'b0, 8'd1);
    idle(4);
    chk("len0_cnt", 32'(match_cnt), 32'd1);
    chk("len0_state", 32'(dbg_state), 32'(READY));

    idle(2);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/seq_detect_ctrl.md
# seq_detect_ctrl

Run-time configurable serial pattern-detection controller. Accepts a pattern and length over a config handshake, is armed by `start`, and watches a valid-qualified serial bit stream. It counts pattern matches and signals completion once a programmed match count is reached. It generalises our fixed-pattern Moore detectors into a reusable block that a host or sequencer can reconfigure between runs.

## Interface
- `PAT_W`, 8: maximum pattern length in bits (≥2).
- `CNT_W`, 8: width of the match target and match counter.
- `TIMEOUT_BITS`, 255: valid-bit budget between matches. Used only when the timeout feature is compiled in.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `cfg_valid` in 1: config offer.
- `cfg_ready` out 1: config accepted when `cfg_valid && cfg_ready`.
- `cfg_pattern` in PAT_W: pattern; bit [len-1] is the first bit received, bit 0 the last.
- `cfg_len` in $clog2(PAT_W)+1: pattern length.
- `cfg_overlap` in 1: 1 = overlapping matches allowed.
- `cfg_target` in CNT_W: number of matches that ends the run.
- `start` in 1: arm the detector.
- `abort` in 1: stop a run without completion.
- `din_valid` in 1: serial bit qualifier.
- `din` in 1: serial data bit.
- `match` out 1: one-cycle pulse per detected match.
- `match_cnt` out CNT_W: number of matches in the current run.
- `busy` out 1: high in RUN.
- `done` out 1: one-cycle completion pulse.
- `timeout` out 1: one-cycle pulse, asserted together with `done` on timeout.

## Operation
- **States:** IDLE, READY, RUN, DONE.
- **IDLE:** `cfg_ready=1`. A config handshake latches all `cfg_*` fields and moves to READY. `start` is ignored.
- **READY:** `cfg_ready=1`; a new handshake overwrites the config. `start` clears the history register, fill counter, `match_cnt` and timeout counter, then enters RUN. If `start` and a config handshake occur together, the config is latched first and then used for the run.
- **RUN:** `cfg_ready=0`, `busy=1`.
  - Each cycle with `din_valid=1` shifts `din` into history bit 0. The fill counter increments, saturating at PAT_W.
  - Cycles with `din_valid=0` change nothing.
  - A match is registered when `fill ≥ len` and `history[len-1:0] == pattern[len-1:0]`, evaluated on the bit just shifted in.
  - On a match: `match` pulses and `match_cnt` increments. If `cfg_overlap=0`, fill resets to 0; otherwise it is kept.
  - If the new count equals the effective target, go to DONE.
- **DONE:** `done=1` for one cycle, then go to READY. The config is retained and `match_cnt` holds its value until the next `start`.
- **Abort:** `abort` in RUN goes to READY on the next edge. No `done`, and `match_cnt` holds. If `abort` coincides with the final match, abort wins: `match` still pulses, but there is no `done`.
- **Length clamp:** a `cfg_len` of 0 or greater than PAT_W is stored as PAT_W.
- **Target:** a `cfg_target` of 0 is treated as 1.
- **Counter:** `match_cnt` never wraps, because the target terminates the run before overflow.

## Timing
- **Reset:** state IDLE; `cfg_ready=1`; `busy`, `match`, `done`, `timeout` = 0; `match_cnt=0`; history and fill cleared.
- **Reset mid-run:** behaves identically to reset. No `done` is emitted.
- **Match latency:** `match` is registered and asserts one cycle after the `din_valid` cycle that carries the completing bit.
- **Run end:** `done` asserts the cycle after the final `match`. `busy` deasserts in the DONE cycle.
- **Start latency:** `busy` rises one cycle after `start` is sampled. The first bit can be shifted in the cycle after that.
- **Output type:** all outputs are registered or decoded from state only (Moore). There is no combinational path from any input to any output.

## Configuration
- **Macro:** `SEQ_DETECT_CTRL_TIMEOUT_EN`.
- **Defined:**
  - A counter counts `din_valid` bits in RUN. It is cleared on `start` and on every match.
  - When it reaches TIMEOUT_BITS without a match, the block enters DONE with `timeout=1` alongside `done`.
  - If a match and the timeout threshold occur on the same bit, the match wins.
- **Undefined:** no counter is built, `timeout` is tied to 0, and runs end only by target or abort.

## Structure
- **Package `seq_detect_pkg`:** state enum (IDLE=2'b00, READY=2'b01, RUN=2'b10, DONE=2'b11) and the length-clamp helper function.
- **Sub-module `seq_shift_match`:** history shift register, fill counter, length-masked comparator. Inputs: `shift`, `bit`, `clr_fill`, `pattern`, `len`. Output: a combinational hit flag. The controller owns the FSM, the counters and the outputs.

## Test plan
1. **Reset:** assert `rst_n=0` for 2 cycles → `cfg_ready=1`, all other outputs 0, and `start` in IDLE is ignored.
2. **Non-overlap:** pattern 8'h0B, len 4, overlap 0, target 2, stream 1,0,1,1,0,1,1 → a single `match` after bit 4, `match_cnt=1`, no `done`.
3. **Overlap:** same stream with overlap 1 → `match` after bits 4 and 7, `match_cnt=2`, and `done` the cycle after the second match.
4. **Valid gaps and abort:** stream 1,0,1,1 with `din_valid` low for 3 cycles between bits → one `match`, timed after the 4th valid bit. Then `abort` → `busy=0` next cycle, `match_cnt=1`, no `done`.
5. **Timeout (macro on, TIMEOUT_BITS=8):** pattern 4'b1011, 8 zero bits → `done` and `timeout` together, `match_cnt=0`.
6. **Reset mid-run, then reconfigure:** `rst_n=0` while in RUN → returns to IDLE with no `done`. Then configure `cfg_len=0` → treated as PAT_W, with no match until 8 valid bits are received.
